// File: rtl/lifo_fifo_pkg.sv
// ----------------------------------------------------------------------------
// lifo_fifo_pkg
// Shared types and defaults for the run-time selectable LIFO/FIFO buffer.
//   mode_e  : buffer discipline (MODE_LIFO = 0, MODE_FIFO = 1)
//   occ_e   : occupancy state (EMPTY / PARTIAL / FULL) decoded from count
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   occ_decode() : maps an occupancy count to occ_e
// ----------------------------------------------------------------------------
package lifo_fifo_pkg;

   typedef enum logic {
      MODE_LIFO = 1'b0,
      MODE_FIFO = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   function automatic occ_e occ_decode(input int cnt, input int depth);
      occ_e res;
      if (cnt == 0) begin
         res = OCC_EMPTY;
      end else if (cnt >= depth) begin
         res = OCC_FULL;
      end else begin
         res = OCC_PARTIAL;
      end
      return res;
   endfunction

endpackage

// File: rtl/lifo_fifo_buffer_if.sv
// ----------------------------------------------------------------------------
// lifo_fifo_buffer_if
// Bus between the tile's decode logic (master) and the buffer (slave).
//   master drives : mode, clear, push, pop, wr_data
//   slave drives  : rd_data, rd_valid, full, empty, count, overflow,
//                   underflow, occ (occupancy state), mode_q (latched mode)
//
// Handshake: push and pop are request strobes sampled on each rising clock
// edge; there is no ready signal. A pop is accepted when count > 0. A push is
// accepted when count < DEPTH or when a pop is accepted in the same cycle.
// Rejected requests change no state. An accepted pop at edge N returns its
// word in rd_data with rd_valid high for exactly the cycle after edge N.
// clear outranks push/pop and empties the buffer.
// ----------------------------------------------------------------------------
interface lifo_fifo_buffer_if #(
   parameter int WIDTH = lifo_fifo_pkg::DEF_WIDTH,
   parameter int DEPTH = lifo_fifo_pkg::DEF_DEPTH
) ();
   import lifo_fifo_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             mode;
   logic             clear;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;
   occ_e             occ;
   mode_e            mode_q;

   modport master (
      output mode, clear, push, pop, wr_data,
      input  rd_data, rd_valid, full, empty, count, overflow, underflow,
             occ, mode_q
   );

   modport slave (
      input  mode, clear, push, pop, wr_data,
      output rd_data, rd_valid, full, empty, count, overflow, underflow,
             occ, mode_q
   );

endinterface

// File: rtl/lifo_fifo_mem.sv
// ----------------------------------------------------------------------------
// lifo_fifo_mem
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset. Address selection lives in
// the parent.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// ----------------------------------------------------------------------------
module lifo_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // A read of the location being written in the same cycle returns the old
   // word, which is what the simultaneous push+pop cases rely on.
   assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_fifo_buffer.sv
// ----------------------------------------------------------------------------
// lifo_fifo_buffer
// Single-clock storage buffer that acts as a stack (LIFO) or a queue (FIFO),
// selected at run time through bus.mode. The mode is only taken while the
// buffer is empty and idle, or on clear.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset of all control state
//   bus   : lifo_fifo_buffer_if.slave (requests in, data/status out)
// Optional feature: define LIFO_FIFO_ERR_EN to enable the sticky overflow /
// underflow flags; otherwise both outputs are tied to 0.
// ----------------------------------------------------------------------------
module lifo_fifo_buffer
   import lifo_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input logic                clk,
   input logic                reset,
   lifo_fifo_buffer_if.slave  bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] count_m1;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   mode_e            mode_q;
   occ_e             occ_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;
   logic             full_q;
   logic             empty_q;

   logic             pop_acc;
   logic             push_acc;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [AW-1:0]    mem_raddr;
   logic [WIDTH-1:0] mem_rdata;

   assign count_m1 = count_q - CNT_W'(1);

   always_comb begin
      pop_acc   = bus.pop && (count_q != '0);
      // A pop in the same cycle frees a slot, so a full buffer still takes it.
      push_acc  = bus.push && ((count_q != DEPTH_C) || pop_acc);
      count_nxt = count_q;
      if (push_acc && !pop_acc) begin
         count_nxt = count_q + CNT_W'(1);
      end else if (pop_acc && !push_acc) begin
         count_nxt = count_m1;
      end

      if (mode_q == MODE_FIFO) begin
         mem_raddr = rd_ptr_q;
         mem_waddr = wr_ptr_q;
      end else begin
         // Stack top is count-1; a push+pop overwrites the top in place.
         mem_raddr = count_m1[AW-1:0];
         mem_waddr = pop_acc ? count_m1[AW-1:0] : count_q[AW-1:0];
      end
      mem_we = push_acc && !bus.clear;
   end

   lifo_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (bus.wr_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // Control FSM: occupancy state EMPTY/PARTIAL/FULL plus the counters and
   // pointers behind it. All outputs are registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mode_q     <= MODE_LIFO;
         occ_q      <= OCC_EMPTY;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else if (bus.clear) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mode_q     <= mode_e'(bus.mode);
         occ_q      <= OCC_EMPTY;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else begin
         rd_valid_q <= pop_acc;
         if (pop_acc) begin
            rd_data_q <= mem_rdata;
         end
         if (mode_q == MODE_FIFO) begin
            if (push_acc) begin
               wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_acc) begin
               rd_ptr_q <= rd_ptr_q + AW'(1);
            end
         end
         count_q <= count_nxt;
         full_q  <= (count_nxt == DEPTH_C);
         empty_q <= (count_nxt == '0);
         occ_q   <= occ_decode(int'(count_nxt), DEPTH);
         // Mode may only change while nothing is stored and nothing arrives.
         if ((count_q == '0) && !push_acc) begin
            mode_q <= mode_e'(bus.mode);
         end
      end
   end

`ifdef LIFO_FIFO_ERR_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clear) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.push && !push_acc) begin
            overflow_q <= 1'b1;
         end
         if (bus.pop && !pop_acc) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.count    = count_q;
   assign bus.occ      = occ_q;
   assign bus.mode_q   = mode_q;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// ----------------------------------------------------------------------------
// tb_lifo_fifo_buffer
// Directed bench for lifo_fifo_buffer (WIDTH=8, DEPTH=4). Pop data is checked
// by a scoreboard: every pop expected to be accepted queues its word, and a
// monitor compares each rd_valid pulse against the queue head. Status outputs
// are checked directly after the relevant edge. Honours LIFO_FIFO_ERR_EN for
// the expected overflow/underflow values.
// ----------------------------------------------------------------------------
module tb_lifo_fifo_buffer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

`ifdef LIFO_FIFO_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk;
   logic reset;

   lifo_fifo_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   lifo_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] mon_exp;
   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp_v);
      total_cnt++;
      if (act === exp_v) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

   // Monitor: every rd_valid pulse must match the oldest expected word.
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL rd_data: got unexpected pulse 0x%0h, expected none",
                     bus.rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bus.rd_data === mon_exp) begin
               pass_cnt++;
            end else begin
               $display("FAIL rd_data: got 0x%0h, expected 0x%0h",
                        bus.rd_data, mon_exp);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; applies one cycle of requests.
   task automatic do_op(input logic ps, input logic pp,
                        input logic [WIDTH-1:0] d);
      bus.push    = ps;
      bus.pop     = pp;
      bus.wr_data = d;
      @(negedge clk);
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
   endtask

   task automatic push_w(input logic [WIDTH-1:0] d);
      do_op(1'b1, 1'b0, d);
   endtask

   task automatic pop_exp(input logic [WIDTH-1:0] e);
      exp_q.push_back(e);
      do_op(1'b0, 1'b1, '0);
   endtask

   task automatic idle(input logic m);
      bus.mode = m;
      do_op(1'b0, 1'b0, '0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset       = 1'b1;
      bus.mode    = 1'b0;
      bus.clear   = 1'b0;
      bus.push    = 1'b1;
      bus.pop     = 1'b1;
      bus.wr_data = 8'h5A;
      repeat (3) @(negedge clk);

      // Reset held with requests active
      check("reset_count", 32'(bus.count), 0);
      check("reset_empty", 32'(bus.empty), 1);
      check("reset_full", 32'(bus.full), 0);
      check("reset_rd_valid", 32'(bus.rd_valid), 0);
      check("reset_rd_data", 32'(bus.rd_data), 0);
      check("reset_overflow", 32'(bus.overflow), 0);
      check("reset_underflow", 32'(bus.underflow), 0);
      check("reset_mode_q", 32'(bus.mode_q), 0);

      // First edge after reset release accepts the pending push
      reset    = 1'b0;
      bus.pop  = 1'b0;
      @(negedge clk);
      bus.push = 1'b0;
      check("first_push_count", 32'(bus.count), 1);
      pop_exp(8'h5A);
      check("first_pop_empty", 32'(bus.empty), 1);

      // LIFO order
      push_w(8'h11);
      push_w(8'h22);
      push_w(8'h33);
      check("lifo_count3", 32'(bus.count), 3);
      check("lifo_occ_partial", 32'(bus.occ), 1);
      pop_exp(8'h33);
      pop_exp(8'h22);
      pop_exp(8'h11);
      check("lifo_empty", 32'(bus.empty), 1);
      idle(1'b1);
      check("lifo_rd_valid_drop", 32'(bus.rd_valid), 0);

      // FIFO fill, overflow, drain, underflow
      check("fifo_mode_latched", 32'(bus.mode_q), 1);
      push_w(8'h11);
      push_w(8'h22);
      push_w(8'h33);
      push_w(8'h44);
      check("fifo_full", 32'(bus.full), 1);
      check("fifo_count4", 32'(bus.count), 4);
      check("fifo_occ_full", 32'(bus.occ), 2);
      push_w(8'h55);
      check("overflow_count", 32'(bus.count), 4);
      check("overflow_flag", 32'(bus.overflow), 32'(ERR_EN));
      pop_exp(8'h11);
      pop_exp(8'h22);
      pop_exp(8'h33);
      pop_exp(8'h44);
      check("fifo_drained", 32'(bus.empty), 1);
      do_op(1'b0, 1'b1, '0);
      check("underflow_flag", 32'(bus.underflow), 32'(ERR_EN));
      check("underflow_rd_valid", 32'(bus.rd_valid), 0);
      check("underflow_rd_data", 32'(bus.rd_data), 32'h44);

      // FIFO full, simultaneous push+pop
      push_w(8'h11);
      push_w(8'h22);
      push_w(8'h33);
      push_w(8'h44);
      exp_q.push_back(8'h11);
      do_op(1'b1, 1'b1, 8'hAA);
      check("fifo_pp_count", 32'(bus.count), 4);
      check("fifo_pp_full", 32'(bus.full), 1);
      pop_exp(8'h22);
      pop_exp(8'h33);
      pop_exp(8'h44);
      pop_exp(8'hAA);

      // LIFO simultaneous push+pop replaces the top
      idle(1'b0);
      check("lifo_mode_latched", 32'(bus.mode_q), 0);
      push_w(8'h11);
      push_w(8'h22);
      exp_q.push_back(8'h22);
      do_op(1'b1, 1'b1, 8'hAA);
      check("lifo_pp_count", 32'(bus.count), 2);
      pop_exp(8'hAA);
      pop_exp(8'h11);

      // FIFO pointer wrap over ten words
      idle(1'b1);
      push_w(8'h01);
      push_w(8'h02);
      for (int i = 3; i <= 10; i++) begin
         exp_q.push_back(8'(i - 2));
         do_op(1'b1, 1'b1, 8'(i));
      end
      check("wrap_count", 32'(bus.count), 2);
      pop_exp(8'h09);
      pop_exp(8'h0A);
      check("wrap_empty", 32'(bus.empty), 1);

      // Mode change while non-empty is ignored
      push_w(8'h61);
      push_w(8'h62);
      idle(1'b0);
      check("mode_ignored", 32'(bus.mode_q), 1);
      pop_exp(8'h61);
      pop_exp(8'h62);
      idle(1'b0);
      check("mode_relatched", 32'(bus.mode_q), 0);

      // clear with push high
      push_w(8'h71);
      push_w(8'h72);
      push_w(8'h73);
      check("pre_clear_count", 32'(bus.count), 3);
      check("pre_clear_overflow", 32'(bus.overflow), 32'(ERR_EN));
      bus.clear = 1'b1;
      do_op(1'b1, 1'b0, 8'h99);
      bus.clear = 1'b0;
      check("clear_count", 32'(bus.count), 0);
      check("clear_empty", 32'(bus.empty), 1);
      check("clear_overflow", 32'(bus.overflow), 0);
      check("clear_underflow", 32'(bus.underflow), 0);
      check("clear_rd_valid", 32'(bus.rd_valid), 0);
      push_w(8'h12);
      pop_exp(8'h12);

      // Asynchronous reset between edges
      push_w(8'h31);
      push_w(8'h32);
      check("pre_reset_count", 32'(bus.count), 2);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_count", 32'(bus.count), 0);
      check("async_reset_empty", 32'(bus.empty), 1);
      @(negedge clk);
      reset = 1'b0;
      push_w(8'h41);
      pop_exp(8'h41);
      idle(1'b0);

      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
